// File: rtl/heart_rate_calc.sv
// Heart-rate calculator: measures peak-to-peak intervals in ms, averages the last four
// plausible intervals and serially converts 60000/avg into binary and BCD beats per minute.
module heart_rate_calc #(
  parameter int TICK_DIV = 40000,
  parameter int MIN_MS   = 300,
  parameter int MAX_MS   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       peak,
  output logic [7:0] bpm,
  output logic [3:0] bpm_hund,
  output logic [3:0] bpm_tens,
  output logic [3:0] bpm_ones,
  output logic       bpm_valid,
  output logic       update,
  output logic       no_pulse
);

  localparam int              PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [11:0]     MIN_C     = 12'(MIN_MS);
  localparam logic [11:0]     MAX_C     = 12'(MAX_MS);
  localparam logic [11:0]     TMO_C     = 12'(MAX_MS + 1);
  localparam logic [15:0]     DIVIDEND  = 16'd60000;

  typedef enum logic [1:0] {IDLE, DIVIDE, CONVERT, PUBLISH} state_t;

  function automatic logic [11:0] ms_inc(input logic [11:0] v);
    return (v == 12'hfff) ? v : v + 12'd1;
  endfunction

  function automatic logic [3:0] dabble_adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  logic [PW-1:0]    presc_q, presc_d;
  logic [11:0]      ms_cnt_q, ms_cnt_d;
  logic             armed_q, armed_d;
  logic [3:0][11:0] hist_q, hist_d;
  logic [13:0]      sum_q, sum_d;
  logic [2:0]       hist_cnt_q, hist_cnt_d;
  logic             req_q, req_d;
  logic             tick, timeout, rearm, accept;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [3:0]       step_q, step_d;
  logic [13:0]      avg_q, avg_d;
  logic [13:0]      rem_q, rem_d;
  logic [15:0]      dq_q, dq_d;
  logic [11:0]      bcd_q, bcd_d;
  logic [14:0]      trial;
  logic [11:0]      bcd_adj;
  logic [7:0]       bpm_q, bpm_d;
  logic [11:0]      dig_q, dig_d;
  logic             valid_q, valid_d;
  logic             update_q, update_d;

  assign tick    = (presc_q == PRESC_MAX);
  assign timeout = armed_q && (ms_cnt_q == TMO_C);
  // A peak landing on the timeout cycle restarts measurement instead of being measured.
  assign rearm   = peak && (!armed_q || timeout);
  assign accept  = peak && armed_q && !timeout && (ms_cnt_q >= MIN_C) && (ms_cnt_q <= MAX_C);

  always_comb begin
    presc_d    = (rearm || accept || tick) ? '0 : presc_q + 1'b1;
    ms_cnt_d   = (rearm || accept) ? '0 : (tick ? ms_inc(ms_cnt_q) : ms_cnt_q);
    armed_d    = rearm ? 1'b1 : (timeout ? 1'b0 : armed_q);
    hist_d     = hist_q;
    sum_d      = sum_q;
    hist_cnt_d = hist_cnt_q;
    req_d      = 1'b0;
    if (timeout) begin
      hist_d     = '0;
      sum_d      = '0;
      hist_cnt_d = '0;
    end else if (accept) begin
      // Slots not yet filled hold zero, so subtracting the oldest is always correct.
      hist_d     = {hist_q[2:0], ms_cnt_q};
      sum_d      = sum_q + {2'b00, ms_cnt_q} - {2'b00, hist_q[3]};
      hist_cnt_d = (hist_cnt_q == 3'd4) ? 3'd4 : hist_cnt_q + 3'd1;
      req_d      = (hist_cnt_d == 3'd4);
    end
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    step_d    = step_q;
    avg_d     = avg_q;
    rem_d     = rem_q;
    dq_d      = dq_q;
    bcd_d     = bcd_q;
    bpm_d     = bpm_q;
    dig_d     = dig_q;
    valid_d   = valid_q;
    update_d  = 1'b0;
    trial     = {rem_q, dq_q[15]};
    bcd_adj   = {dabble_adj(bcd_q[11:8]), dabble_adj(bcd_q[7:4]), dabble_adj(bcd_q[3:0])};
    if (req_q && (state_q != IDLE)) pending_d = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (req_q || pending_q) begin
          avg_d     = sum_q >> 2;
          rem_d     = '0;
          dq_d      = DIVIDEND;
          step_d    = '0;
          pending_d = 1'b0;
          state_d   = DIVIDE;
        end
      end
      DIVIDE: begin
        // dq shifts dividend bits out at the top and quotient bits in at the bottom.
        if (trial >= {1'b0, avg_q}) begin
          rem_d = trial[13:0] - avg_q;
          dq_d  = {dq_q[14:0], 1'b1};
        end else begin
          rem_d = trial[13:0];
          dq_d  = {dq_q[14:0], 1'b0};
        end
        step_d = step_q + 4'd1;
        if (step_q == 4'd15) begin
          bcd_d   = '0;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        // Low byte rotates so the binary quotient is intact again after 8 steps.
        bcd_d  = 12'({bcd_adj, dq_q[7]});
        dq_d   = {dq_q[15:8], dq_q[6:0], dq_q[7]};
        step_d = step_q + 4'd1;
        if (step_q == 4'd7) begin
          step_d  = '0;
          state_d = PUBLISH;
        end
      end
      PUBLISH: begin
        bpm_d    = dq_q[7:0];
        dig_d    = bcd_q;
        valid_d  = 1'b1;
        update_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (timeout) begin
      state_d   = IDLE;
      pending_d = 1'b0;
      bpm_d     = '0;
      dig_d     = '0;
      valid_d   = 1'b0;
      update_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q    <= '0;
      ms_cnt_q   <= '0;
      armed_q    <= 1'b0;
      hist_q     <= '0;
      sum_q      <= '0;
      hist_cnt_q <= '0;
      req_q      <= 1'b0;
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      step_q     <= '0;
      bpm_q      <= '0;
      dig_q      <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      ms_cnt_q   <= ms_cnt_d;
      armed_q    <= armed_d;
      hist_q     <= hist_d;
      sum_q      <= sum_d;
      hist_cnt_q <= hist_cnt_d;
      req_q      <= req_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      step_q     <= step_d;
      bpm_q      <= bpm_d;
      dig_q      <= dig_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
    end
  end

  // Divider/converter working registers are always loaded before they are read.
  always_ff @(posedge clk) begin
    avg_q <= avg_d;
    rem_q <= rem_d;
    dq_q  <= dq_d;
    bcd_q <= bcd_d;
  end

  assign bpm       = bpm_q;
  assign bpm_hund  = dig_q[11:8];
  assign bpm_tens  = dig_q[7:4];
  assign bpm_ones  = dig_q[3:0];
  assign bpm_valid = valid_q;
  assign update    = update_q;
  assign no_pulse  = ~armed_q;

endmodule

// File: tb/tb_heart_rate_calc.sv
// Directed bench for heart_rate_calc at one tick per clock; a second instance with a
// short minimum interval lets accepted peaks arrive while a computation is in flight.
module tb_heart_rate_calc;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       peak = 1'b0;
  logic       peak_p = 1'b0;
  logic [7:0] bpm, bpm_p;
  logic [3:0] bpm_hund, bpm_tens, bpm_ones;
  logic [3:0] bpm_hund_p, bpm_tens_p, bpm_ones_p;
  logic       bpm_valid, update, no_pulse;
  logic       bpm_valid_p, update_p, no_pulse_p;

  int cyc = 0;
  int upd_cnt = 0, upd_edge = -1;
  int upd_cnt_p = 0, upd_edge_p = -1;
  int pass_cnt = 0, tot_cnt = 0;
  int last_pk = 0;

  always #5 clk = ~clk;

  heart_rate_calc #(.TICK_DIV(1), .MIN_MS(300), .MAX_MS(2000)) dut (
    .clk(clk), .reset(reset), .peak(peak), .bpm(bpm), .bpm_hund(bpm_hund),
    .bpm_tens(bpm_tens), .bpm_ones(bpm_ones), .bpm_valid(bpm_valid),
    .update(update), .no_pulse(no_pulse)
  );

  heart_rate_calc #(.TICK_DIV(1), .MIN_MS(4), .MAX_MS(2000)) dut_p (
    .clk(clk), .reset(reset), .peak(peak_p), .bpm(bpm_p), .bpm_hund(bpm_hund_p),
    .bpm_tens(bpm_tens_p), .bpm_ones(bpm_ones_p), .bpm_valid(bpm_valid_p),
    .update(update_p), .no_pulse(no_pulse_p)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (update) begin
      upd_cnt  = upd_cnt + 1;
      upd_edge = cyc;
    end
    if (update_p) begin
      upd_cnt_p  = upd_cnt_p + 1;
      upd_edge_p = cyc;
    end
  end

  task automatic do_reset;
    reset = 1'b0; peak = 1'b0; peak_p = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Called at a negedge; the peak is sampled by the next posedge, recorded in last_pk.
  task automatic pulse_peak(input bit on_p);
    if (on_p) peak_p = 1'b1; else peak = 1'b1;
    @(negedge clk);
    peak = 1'b0; peak_p = 1'b0;
    last_pk = cyc;
  endtask

  task automatic gap_peak(input int gap, input bit on_p);
    repeat (gap - 1) @(negedge clk);
    pulse_peak(on_p);
  endtask

  task automatic train(input int n, input int gap, input bit on_p);
    pulse_peak(on_p);
    for (int i = 1; i < n; i++) gap_peak(gap, on_p);
  endtask

  task automatic test_reset;
    do_reset();
    repeat (100) @(negedge clk);
    #1;
    tot_cnt++;
    if ({bpm, bpm_hund, bpm_tens, bpm_ones} !== 20'h0)
      $display("FAIL reset_value: got %h want 00000", {bpm, bpm_hund, bpm_tens, bpm_ones});
    else pass_cnt++;
    tot_cnt++;
    if ({bpm_valid, update, no_pulse} !== 3'b001)
      $display("FAIL reset_flags: got %b want 001", {bpm_valid, update, no_pulse});
    else pass_cnt++;
    tot_cnt++;
    if ({bpm_p, bpm_valid_p, update_p, no_pulse_p} !== 11'b00000000_001)
      $display("FAIL reset_p: got %b want 00000000001", {bpm_p, bpm_valid_p, update_p, no_pulse_p});
    else pass_cnt++;
    tot_cnt++;
    if (upd_cnt + upd_cnt_p !== 0)
      $display("FAIL reset_no_update: got %0d want 0", upd_cnt + upd_cnt_p);
    else pass_cnt++;
  endtask

  task automatic test_steady;
    int b, p;
    do_reset();
    b = upd_cnt;
    train(5, 1000, 1'b0);
    p = last_pk;
    repeat (40) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt - b !== 1) $display("FAIL steady_count: got %0d want 1", upd_cnt - b);
    else pass_cnt++;
    tot_cnt++;
    if (upd_edge - p !== 26) $display("FAIL steady_latency: got %0d want 26", upd_edge - p);
    else pass_cnt++;
    tot_cnt++;
    if ({bpm, bpm_hund, bpm_tens, bpm_ones} !== {8'd60, 12'h060})
      $display("FAIL steady_bpm: got %h want 3c060", {bpm, bpm_hund, bpm_tens, bpm_ones});
    else pass_cnt++;
    tot_cnt++;
    if ({bpm_valid, no_pulse} !== 2'b10)
      $display("FAIL steady_flags: got %b want 10", {bpm_valid, no_pulse});
    else pass_cnt++;
  endtask

  task automatic test_mixed;
    int b;
    int exp_b [4] = '{106, 96, 87, 80};
    logic [11:0] exp_d [4] = '{12'h106, 12'h096, 12'h087, 12'h080};
    do_reset();
    b = upd_cnt;
    train(5, 500, 1'b0);
    repeat (27) @(negedge clk);
    #1;
    tot_cnt++;
    if ({bpm, bpm_hund, bpm_tens, bpm_ones} !== {8'd120, 12'h120} || upd_cnt - b !== 1)
      $display("FAIL mixed_first: got %0d %h n=%0d want 120 120 n=1",
               bpm, {bpm_hund, bpm_tens, bpm_ones}, upd_cnt - b);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      gap_peak(750 - 27, 1'b0);
      repeat (27) @(negedge clk);
      #1;
      tot_cnt++;
      if (bpm !== exp_b[i] || {bpm_hund, bpm_tens, bpm_ones} !== exp_d[i] || upd_cnt - b !== i + 2)
        $display("FAIL mixed_step%0d: got %0d %h n=%0d want %0d %h n=%0d", i, bpm,
                 {bpm_hund, bpm_tens, bpm_ones}, upd_cnt - b, exp_b[i], exp_d[i], i + 2);
      else pass_cnt++;
    end
  endtask

  task automatic test_bounds;
    int b;
    do_reset();
    train(5, 301, 1'b0);
    repeat (27) @(negedge clk);
    #1;
    tot_cnt++;
    if ({bpm, bpm_hund, bpm_tens, bpm_ones, bpm_valid} !== {8'd200, 12'h200, 1'b1})
      $display("FAIL bound_min: got %0d %h v=%b want 200 200 v=1", bpm,
               {bpm_hund, bpm_tens, bpm_ones}, bpm_valid);
    else pass_cnt++;
    do_reset();
    train(5, 2001, 1'b0);
    repeat (27) @(negedge clk);
    #1;
    tot_cnt++;
    if ({bpm, bpm_hund, bpm_tens, bpm_ones, no_pulse} !== {8'd30, 12'h030, 1'b0})
      $display("FAIL bound_max: got %0d %h np=%b want 30 030 np=0", bpm,
               {bpm_hund, bpm_tens, bpm_ones}, no_pulse);
    else pass_cnt++;
    // 299 ms intervals are below the minimum; only every other peak is accepted.
    do_reset();
    b = upd_cnt;
    train(5, 300, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt - b !== 0 || bpm_valid !== 1'b0)
      $display("FAIL bound_reject: got n=%0d v=%b want n=0 v=0", upd_cnt - b, bpm_valid);
    else pass_cnt++;
  endtask

  task automatic test_ignore;
    int b, p;
    do_reset();
    b = upd_cnt;
    pulse_peak(1'b0);
    gap_peak(1000, 1'b0);
    gap_peak(100, 1'b0);
    gap_peak(900, 1'b0);
    gap_peak(1000, 1'b0);
    gap_peak(1000, 1'b0);
    p = last_pk;
    repeat (40) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt - b !== 1 || upd_edge - p !== 26)
      $display("FAIL ignore_update: got n=%0d lat=%0d want n=1 lat=26", upd_cnt - b, upd_edge - p);
    else pass_cnt++;
    tot_cnt++;
    if (bpm !== 8'd60) $display("FAIL ignore_bpm: got %0d want 60", bpm);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    int b, p;
    do_reset();
    train(5, 1000, 1'b0);
    p = last_pk;
    repeat (1990) @(negedge clk);
    #1;
    tot_cnt++;
    if ({no_pulse, bpm_valid, bpm} !== {1'b0, 1'b1, 8'd60})
      $display("FAIL timeout_early: got np=%b v=%b bpm=%0d want np=0 v=1 bpm=60",
               no_pulse, bpm_valid, bpm);
    else pass_cnt++;
    repeat (20) @(negedge clk);
    #1;
    tot_cnt++;
    if ({no_pulse, bpm_valid, bpm, bpm_hund, bpm_tens, bpm_ones} !== {1'b1, 1'b0, 20'h0})
      $display("FAIL timeout_clear: got np=%b v=%b bpm=%0d dig=%h want np=1 v=0 bpm=0 dig=000",
               no_pulse, bpm_valid, bpm, {bpm_hund, bpm_tens, bpm_ones});
    else pass_cnt++;
    b = upd_cnt;
    train(4, 1000, 1'b0);
    repeat (40) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt - b !== 0 || no_pulse !== 1'b0)
      $display("FAIL timeout_rearm: got n=%0d np=%b want n=0 np=0", upd_cnt - b, no_pulse);
    else pass_cnt++;
    gap_peak(1000 - 40, 1'b0);
    p = last_pk;
    repeat (27) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt - b !== 1 || upd_edge - p !== 26 || bpm !== 8'd60)
      $display("FAIL timeout_refill: got n=%0d lat=%0d bpm=%0d want n=1 lat=26 bpm=60",
               upd_cnt - b, upd_edge - p, bpm);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int b;
    do_reset();
    train(5, 1000, 1'b0);
    repeat (27) @(negedge clk);
    #1;
    b = upd_cnt;
    tot_cnt++;
    if (bpm !== 8'd60) $display("FAIL midrst_pre: got %0d want 60", bpm);
    else pass_cnt++;
    gap_peak(1000 - 27, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #2;
    tot_cnt++;
    if ({bpm, bpm_hund, bpm_tens, bpm_ones, bpm_valid, update, no_pulse} !== {20'h0, 3'b001})
      $display("FAIL midrst_async: got bpm=%0d v=%b u=%b np=%b want 0 0 0 1",
               bpm, bpm_valid, update, no_pulse);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt !== b || bpm !== 8'd0 || no_pulse !== 1'b1)
      $display("FAIL midrst_quiet: got n=%0d bpm=%0d np=%b want n=%0d bpm=0 np=1",
               upd_cnt, bpm, no_pulse, b);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int b, p;
    do_reset();
    b = upd_cnt_p;
    train(5, 1001, 1'b1);
    p = last_pk;
    gap_peak(5, 1'b1);
    gap_peak(5, 1'b1);
    repeat (17) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt_p - b !== 1 || upd_edge_p - p !== 26 || bpm_p !== 8'd60)
      $display("FAIL b2b_first: got n=%0d lat=%0d bpm=%0d want n=1 lat=26 bpm=60",
               upd_cnt_p - b, upd_edge_p - p, bpm_p);
    else pass_cnt++;
    repeat (26) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt_p - b !== 2 || upd_edge_p - p !== 52)
      $display("FAIL b2b_second: got n=%0d lat=%0d want n=2 lat=52", upd_cnt_p - b, upd_edge_p - p);
    else pass_cnt++;
    tot_cnt++;
    if ({bpm_p, bpm_hund_p, bpm_tens_p, bpm_ones_p} !== {8'd119, 12'h119})
      $display("FAIL b2b_bpm: got %0d %h want 119 119", bpm_p, {bpm_hund_p, bpm_tens_p, bpm_ones_p});
    else pass_cnt++;
    repeat (60) @(negedge clk);
    #1;
    tot_cnt++;
    if (upd_cnt_p - b !== 2) $display("FAIL b2b_total: got %0d want 2", upd_cnt_p - b);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_mixed();
    test_bounds();
    test_ignore();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
